// File: rtl/net_access_controller.sv
// ---------------------------------------------------------------------------
// net_access_controller
//   Sequences SWNET / LWNET accesses from the MEM stage onto a NoC router
//   port. Outgoing words are queued in a TX FIFO and incoming words in an
//   RX FIFO. BUSYWAIT stalls the pipeline when an access cannot complete
//   in the current cycle.
//
//   Optional feature (macro NET_TIMEOUT_EN): an LWNET that waits
//   TIMEOUT_CYCLES cycles on an empty RX FIFO returns all-ones data with
//   RX_LAST_SRC all-ones. Without the macro an LWNET waits indefinitely.
//
// Ports:
//   CLK, RESET               clock (rising edge), synchronous active-low reset
//   NI_WRITE, NI_READ        SWNET / LWNET in MEM stage
//   ADDR, WRITE_DATA         destination node (low bits) and SWNET payload
//   READ_DATA, BUSYWAIT      LWNET result and pipeline stall request
//   TX_VALID/READY/DEST/DATA router-bound head of the TX FIFO
//   RX_VALID/READY/SRC/DATA  router-delivered words into the RX FIFO
//   RX_LAST_SRC              source node of the last word returned by LWNET
// ---------------------------------------------------------------------------
module net_access_controller #(
    parameter int DATA_WIDTH     = 32,
    parameter int NODE_WIDTH     = 8,
    parameter int TX_DEPTH       = 4,
    parameter int RX_DEPTH       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  NI_WRITE,
    input  logic                  NI_READ,
    input  logic [31:0]           ADDR,
    input  logic [DATA_WIDTH-1:0] WRITE_DATA,
    output logic [DATA_WIDTH-1:0] READ_DATA,
    output logic                  BUSYWAIT,
    output logic                  TX_VALID,
    input  logic                  TX_READY,
    output logic [NODE_WIDTH-1:0] TX_DEST,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    input  logic                  RX_VALID,
    output logic                  RX_READY,
    input  logic [NODE_WIDTH-1:0] RX_SRC,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    output logic [NODE_WIDTH-1:0] RX_LAST_SRC
);
    localparam int TXA = $clog2(TX_DEPTH);
    localparam int RXA = $clog2(RX_DEPTH);
    localparam int EW  = NODE_WIDTH + DATA_WIDTH;

    typedef enum logic [0:0] {R_IDLE, R_WAIT} rstate_t;

    logic [EW-1:0]         tx_mem_q [TX_DEPTH];
    logic [EW-1:0]         rx_mem_q [RX_DEPTH];
    logic [TXA-1:0]        tx_wr_q, tx_rd_q;
    logic [RXA-1:0]        rx_wr_q, rx_rd_q;
    logic [TXA:0]          tx_cnt_q, tx_cnt_d;
    logic [RXA:0]          rx_cnt_q, rx_cnt_d;
    rstate_t               state_q;
    logic [NODE_WIDTH-1:0] last_src_q;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic rd_req, rx_serve, tx_stall, rx_stall, timeout;

    // Only the node-id bits of ADDR are meaningful here.
    logic unused_addr;
    assign unused_addr = ^ADDR[31:NODE_WIDTH];

`ifdef NET_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WCW-1:0] wait_cnt_q;
    assign timeout = (state_q == R_WAIT) && rd_req && rx_empty &&
                     (wait_cnt_q == WCW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout = 1'b0;
`endif

    assign tx_full  = (tx_cnt_q == (TXA+1)'(TX_DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == (RXA+1)'(RX_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);

    // Full is judged before any same-edge pop, so a push into a full FIFO
    // always waits a cycle.
    assign tx_push  = RESET && NI_WRITE && !tx_full;
    assign tx_stall = RESET && NI_WRITE && tx_full;
    assign TX_VALID = RESET && !tx_empty;
    assign tx_pop   = TX_VALID && TX_READY;
    assign {TX_DEST, TX_DATA} = tx_mem_q[tx_rd_q];

    assign RX_READY = RESET && !rx_full;
    assign rx_push  = RX_VALID && RX_READY;

    // A simultaneous write wins; the read is dropped.
    assign rd_req   = RESET && NI_READ && !NI_WRITE;
    // Serving is identical in R_IDLE and R_WAIT: any word at the head
    // completes the LWNET this cycle.
    assign rx_serve = rd_req && !rx_empty;
    assign rx_pop   = rx_serve;
    assign rx_stall = rd_req && rx_empty && !timeout;

    assign BUSYWAIT    = tx_stall || rx_stall;
    assign READ_DATA   = rx_serve ? rx_mem_q[rx_rd_q][DATA_WIDTH-1:0] :
                         timeout  ? '1 : '0;
    assign RX_LAST_SRC = last_src_q;

    always_comb begin
        tx_cnt_d = tx_cnt_q + (TXA+1)'(tx_push) - (TXA+1)'(tx_pop);
        rx_cnt_d = rx_cnt_q + (RXA+1)'(rx_push) - (RXA+1)'(rx_pop);
    end

    // Storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= {ADDR[NODE_WIDTH-1:0], WRITE_DATA};
        if (rx_push) rx_mem_q[rx_wr_q] <= {RX_SRC, RX_DATA};
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_cnt_q   <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_cnt_q   <= '0;
            state_q    <= R_IDLE;
            last_src_q <= '0;
`ifdef NET_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            // Pointers wrap naturally since depths are powers of two.
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;

            case (state_q)
                R_IDLE:  if (rd_req && rx_empty) state_q <= R_WAIT;
                R_WAIT:  if (!rd_req || !rx_empty || timeout) state_q <= R_IDLE;
                default: state_q <= R_IDLE;
            endcase

            if (rx_serve)     last_src_q <= rx_mem_q[rx_rd_q][EW-1:DATA_WIDTH];
            else if (timeout) last_src_q <= '1;

`ifdef NET_TIMEOUT_EN
            if (state_q == R_WAIT && rx_stall) wait_cnt_q <= wait_cnt_q + 1'b1;
            else                               wait_cnt_q <= '0;
`endif
        end
    end
endmodule

// File: doc/net_access_controller.md
Name: net_access_controller

Overview:
- Sequences the pipeline's network-interface accesses: SWNET (opcode 0101111) and LWNET (opcode 0111111).
- Sits between the MEM stage and the NoC router port.
- Buffers outgoing words in a TX FIFO and incoming words in an RX FIFO.
- Stalls the pipeline through BUSYWAIT when an access cannot complete this cycle.
- Driven by the control unit's network_interface_write / network_interface_read signals, pipelined to MEM.

Parameters:
- DATA_WIDTH, 32, payload width.
- NODE_WIDTH, 8, node-id width. Destination is ADDR[NODE_WIDTH-1:0].
- TX_DEPTH, 4, TX FIFO entries. Power of 2, ≥2.
- RX_DEPTH, 4, RX FIFO entries. Power of 2, ≥2.
- TIMEOUT_CYCLES, 1024, LWNET wait limit. Used only with the optional feature.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-low reset.
- NI_WRITE  in  1  SWNET in MEM stage.
- NI_READ  in  1  LWNET in MEM stage.
- ADDR  in  32  ALU result; low NODE_WIDTH bits are the destination node.
- WRITE_DATA  in  DATA_WIDTH  SWNET payload (rs2).
- READ_DATA  out  DATA_WIDTH  LWNET result to writeback.
- BUSYWAIT  out  1  pipeline stall request.
- TX_VALID  out  1  TX head valid to router.
- TX_READY  in  1  router accepts TX head.
- TX_DEST  out  NODE_WIDTH  TX head destination.
- TX_DATA  out  DATA_WIDTH  TX head payload.
- RX_VALID  in  1  router presents a word.
- RX_READY  out  1  controller can accept a word.
- RX_SRC  in  NODE_WIDTH  source node of the RX word.
- RX_DATA  in  DATA_WIDTH  RX payload.
- RX_LAST_SRC  out  NODE_WIDTH  source of the last word returned by LWNET.

Behaviour:
- **Reset:** RESET low at a CLK edge does the following.
  - Both FIFOs emptied (pointers and counts = 0).
  - Read FSM set to R_IDLE, wait counter = 0, RX_LAST_SRC = 0.
  - While RESET is low: TX_VALID = 0, RX_READY = 0, BUSYWAIT = 0, READ_DATA = 0.
  - Reset mid-stall drops the pending access. The pipeline is flushed by its own reset.
- **TX path (SWNET):**
  - NI_WRITE & ~tx_full: {ADDR[NODE_WIDTH-1:0], WRITE_DATA} pushed at the edge. BUSYWAIT = 0 that cycle, giving zero-cycle completion.
  - NI_WRITE & tx_full: BUSYWAIT = 1 combinationally. The pipeline holds NI_WRITE, ADDR and WRITE_DATA stable. The push happens on the first edge where the FIFO is not full.
  - Push and pop on the same edge when full: not allowed. Full is judged before the pop, so the push waits one cycle.
- **TX drain:**
  - TX_VALID = ~tx_empty; TX_DEST and TX_DATA come from the head entry.
  - Pop on TX_VALID & TX_READY.
  - Push and pop on the same edge are allowed when not full; the count is unchanged.
  - Pointers wrap modulo depth.
- **RX fill:**
  - RX_READY = ~rx_full.
  - {RX_SRC, RX_DATA} is pushed on RX_VALID & RX_READY.
  - A word arriving into an empty FIFO is visible to LWNET one cycle later. There is no bypass.
- **Read FSM (LWNET):**
  - R_IDLE:
    - NI_READ & ~rx_empty: READ_DATA = head data, BUSYWAIT = 0. Pop and RX_LAST_SRC <= head src at the edge.
    - NI_READ & rx_empty: BUSYWAIT = 1, go to R_WAIT.
    - Otherwise READ_DATA = 0.
  - R_WAIT:
    - BUSYWAIT = 1 while rx_empty; the wait counter increments each cycle.
    - When rx_empty drops, serve as in R_IDLE in that cycle (BUSYWAIT = 0), then return to R_IDLE with counter = 0.
  - If NI_READ deasserts in R_WAIT (flush), return to R_IDLE with no pop.
  - RX pop and RX push on the same edge are allowed.
- **Illegal input:** NI_WRITE & NI_READ both high. The write is serviced, the read is ignored, and READ_DATA = 0.
- **Stall signal:** BUSYWAIT is the OR of the TX stall and the RX stall terms.

Optional Feature:
- **Macro NET_TIMEOUT_EN defined:**
  - When the wait counter reaches TIMEOUT_CYCLES-1 in R_WAIT with rx_empty, the next cycle returns READ_DATA = 32'hFFFFFFFF with BUSYWAIT = 0 and no pop.
  - RX_LAST_SRC is set to all-ones. The FSM returns to R_IDLE.
  - Counter width is $clog2(TIMEOUT_CYCLES)+1.
- **Macro undefined:** LWNET waits indefinitely. The counter logic is removed.

Test Plan:
- **Reset:** RESET=0 for 2 cycles with RX_VALID=1 → RX_READY=0, TX_VALID=0, BUSYWAIT=0. After release, RX_READY=1 and RX FIFO empty.
- **SWNET to full:** 5 SWNETs (ADDR=0x03, data 0xA0..0xA4) with TX_READY=0 → first 4 with BUSYWAIT=0, 5th stalls. Raise TX_READY → 5th push one cycle after the first pop. Router sees dest 0x03, data 0xA0..0xA4 in order.
- **LWNET hit:** preload RX with src 0x07, data 0xDEADBEEF, then NI_READ → same-cycle READ_DATA=0xDEADBEEF, BUSYWAIT=0; RX_LAST_SRC=0x07 next cycle.
- **LWNET miss:** NI_READ with RX empty, word 0x1234 arrives 5 cycles later → BUSYWAIT high 6 cycles, READ_DATA=0x1234 in the release cycle.
- **Concurrency:** TX push plus TX pop and RX push plus RX pop in the same cycle at half-full → counts unchanged, data order preserved across pointer wrap (≥10 words).
- **Timeout:** with NET_TIMEOUT_EN and TIMEOUT_CYCLES=16, NI_READ on empty RX → READ_DATA=0xFFFFFFFF after 16 stall cycles, RX_LAST_SRC all-ones. Without the macro, BUSYWAIT stays high for 100 cycles.
